// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_pkg
// Description : Shared mode encoding for the set/reset DFF bank and its
//               per-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_LOAD = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_SHR  = 2'b11;

endpackage : dff_pkg
`default_nettype wire

// File: rtl/dff_bit_p_sr.sv
`default_nettype none
// ============================================================================
// Module      : dff_bit_p_sr
// Description : One bit of the DFF bank. Asynchronous active-low reset,
//               synchronous clear/set, enable and hold/load/shift modes.
//               i_left is the more significant neighbour (source on a right
//               shift), i_right the less significant one (source on a left
//               shift). The next-state value is exported so the bank can
//               detect a change before the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bit_p_sr
  import dff_pkg::*;
(
  input  logic  clk,
  input  logic  Reset,
  input  logic  i_clr,
  input  logic  i_set,
  input  logic  i_set_val,
  input  logic  i_rst_val,
  input  logic  i_en,
  input  mode_t i_mode,
  input  logic  i_d,
  input  logic  i_left,
  input  logic  i_right,
  output logic  o_q,
  output logic  o_q_next
);

  logic r_q;
  logic w_q_next;

  // Next-state selection: clear beats set, set beats the enabled mode.
  always_comb begin
    w_q_next = r_q;
    if (i_clr) begin
      w_q_next = 1'b0;
    end else if (i_set) begin
      w_q_next = i_set_val;
    end else if (i_en) begin
      case (i_mode)
        MODE_LOAD: w_q_next = i_d;
        MODE_SHL:  w_q_next = i_right;
        MODE_SHR:  w_q_next = i_left;
        default:   w_q_next = r_q;
      endcase
    end
  end

  // State flop with asynchronous reset to the configured reset bit.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_q <= i_rst_val;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign o_q      = r_q;
  assign o_q_next = w_q_next;

endmodule : dff_bit_p_sr
`default_nettype wire

// File: rtl/dff_bank_p_sr.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_p_sr
// Description : WIDTH-bit bank of positive-edge DFFs with asynchronous reset,
//               synchronous clear/set, clock enable, parallel load, left and
//               right shift, serial in/out and a registered change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_p_sr
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Set,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] n_q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             changed
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic             r_changed;

  // Neighbour chaining: ser_in enters at the MSB on a right shift and at the
  // LSB on a left shift.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == WIDTH - 1) begin : g_msb
      assign w_left[i] = ser_in;
    end else begin : g_mid_l
      assign w_left[i] = w_q[i+1];
    end

    if (i == 0) begin : g_lsb
      assign w_right[i] = ser_in;
    end else begin : g_mid_r
      assign w_right[i] = w_q[i-1];
    end

    dff_bit_p_sr u_bit (
      .clk       (clk),
      .Reset     (Reset),
      .i_clr     (Clr),
      .i_set     (Set),
      .i_set_val (SET_VAL[i]),
      .i_rst_val (RST_VAL[i]),
      .i_en      (en),
      .i_mode    (mode),
      .i_d       (d[i]),
      .i_left    (w_left[i]),
      .i_right   (w_right[i]),
      .o_q       (w_q[i]),
      .o_q_next  (w_q_next[i])
    );
  end

  // Change flag: set when the coming edge writes a value different from q.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= (w_q_next != w_q);
    end
  end

  assign q         = w_q;
  assign n_q       = ~w_q;
  assign ser_out_l = w_q[WIDTH-1];
  assign ser_out_r = w_q[0];
  assign changed   = r_changed;

endmodule : dff_bank_p_sr
`default_nettype wire
